cdb_wb_arbiter: RTL and testbench

- Shares a single registered common-data-bus broadcast slot between N_SRC functional-unit writeback sources (ALU, MUL, BR, MEM by convention, indices 0..3).
- Each source pushes completed results (rob_idx, rd_addr, data) into a private small FIFO.
- A round-robin arbiter pops at most one FIFO head per cycle into the output register that drives the CDB seen by the reservation stations and ROB.
- A flush discards all pending results.

---
 rtl/cdb_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_wb_arbiter.sv
// Common-data-bus writeback arbiter.
// Each writeback source owns a small circular FIFO. A round-robin arbiter
// pops at most one FIFO head per cycle into a registered CDB broadcast slot.
// A flush empties every FIFO and cancels the broadcast being loaded.
module cdb_wb_arbiter #(
    parameter int N_SRC         = 4,
    parameter int FIFO_DEPTH    = 2,
    parameter int ROB_IDX_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    localparam int SRC_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic [N_SRC-1:0]                       src_valid,
    output logic [N_SRC-1:0]                       src_ready,
    input  logic [N_SRC-1:0][ROB_IDX_WIDTH-1:0]    src_rob_idx,
    input  logic [N_SRC-1:0][4:0]                  src_rd_addr,
    input  logic [N_SRC-1:0][DATA_WIDTH-1:0]       src_data,
    output logic                                   cdb_valid,
    output logic [SRC_W-1:0]                       cdb_src,
    output logic [ROB_IDX_WIDTH-1:0]               cdb_rob_idx,
    output logic [4:0]                             cdb_rd_addr,
    output logic [DATA_WIDTH-1:0]                  cdb_data
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ROB_IDX_WIDTH + 5 + DATA_WIDTH;

    logic [N_SRC-1:0]   push;
    logic [N_SRC-1:0]   pop;
    logic [N_SRC-1:0]   req;
    logic [ENTRY_W-1:0] head [N_SRC];

    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   rr_ptr_reg;
    logic [SRC_W-1:0]   rr_ptr_next;
    logic [ENTRY_W-1:0] head_sel;

    // Per-source FIFOs. Readiness comes only from the registered count, so a
    // pop in the same cycle never opens a slot for a simultaneous push.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [CNT_W-1:0]   count_reg;

            assign src_ready[gi] = (count_reg != CNT_W'(FIFO_DEPTH));
            assign req[gi]       = (count_reg != '0);
            assign push[gi]      = src_valid[gi] & src_ready[gi] & ~flush;
            assign pop[gi]       = grant_valid & (grant_idx == SRC_W'(gi)) & ~flush;
            assign head[gi]      = mem[rd_ptr_reg];

            // Entry storage; contents are only read while count is non-zero.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= {src_rob_idx[gi], src_rd_addr[gi], src_data[gi]};
                end
            end

            // Pointer and occupancy bookkeeping; flush empties the FIFO.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    // Scanning offsets from the far end lets the nearest requester win last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req[SRC_W'((int'(rr_ptr_reg) + k) % N_SRC)]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'((int'(rr_ptr_reg) + k) % N_SRC);
            end
        end
    end

    // Next priority pointer sits just past the granted source.
    always_comb begin
        rr_ptr_next = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
        head_sel    = head[grant_idx];
    end

    // Registered CDB slot and rotating priority. Payload holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid   <= 1'b0;
            cdb_src     <= '0;
            cdb_rob_idx <= '0;
            cdb_rd_addr <= '0;
            cdb_data    <= '0;
            rr_ptr_reg  <= '0;
        end else if (flush) begin
            cdb_valid   <= 1'b0;
        end else if (grant_valid) begin
            cdb_valid   <= 1'b1;
            cdb_src     <= grant_idx;
            cdb_rob_idx <= head_sel[ENTRY_W-1 -: ROB_IDX_WIDTH];
            cdb_rd_addr <= head_sel[DATA_WIDTH +: 5];
            cdb_data    <= head_sel[DATA_WIDTH-1:0];
            rr_ptr_reg  <= rr_ptr_next;
        end else begin
            cdb_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Testbench for cdb_wb_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the arbiter behaviour.
module tb_cdb_wb_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [N-1:0]         src_valid;
    logic [N-1:0]         src_ready;
    logic [N-1:0][4:0]    src_rob_idx;
    logic [N-1:0][4:0]    src_rd_addr;
    logic [N-1:0][31:0]   src_data;
    logic                 cdb_valid;
    logic [1:0]           cdb_src;
    logic [4:0]           cdb_rob_idx;
    logic [4:0]           cdb_rd_addr;
    logic [31:0]          cdb_data;

    cdb_wb_arbiter #(
        .N_SRC(N), .FIFO_DEPTH(DEPTH), .ROB_IDX_WIDTH(5), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rob_idx(src_rob_idx), .src_rd_addr(src_rd_addr), .src_data(src_data),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_idx(cdb_rob_idx),
        .cdb_rd_addr(cdb_rd_addr), .cdb_data(cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rob;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Model: one queue per source, a priority index, and the expected slot.
    ent_t        q [N][$];
    int          rr;
    logic        exp_valid;
    logic [1:0]  exp_src;
    logic [4:0]  exp_rob;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit bp_rec = 1'b0;
    logic [4:0] bp_robs [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rdy [N];
        int g;
        ent_t e;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0; exp_valid = 0; exp_src = 0; exp_rob = 0; exp_rd = 0; exp_data = 0;
            return;
        end
        g = -1;
        for (int i = 0; i < N; i++) rdy[i] = (q[i].size() != DEPTH);
        for (int k = 0; k < N; k++) begin
            if (g < 0 && q[(rr + k) % N].size() > 0) g = (rr + k) % N;
        end
        if (flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            exp_valid = 0;
        end else begin
            if (g >= 0) begin
                e = q[g].pop_front();
                exp_valid = 1; exp_src = 2'(g);
                exp_rob = e.rob; exp_rd = e.rd; exp_data = e.data;
                rr = (g + 1) % N;
            end else begin
                exp_valid = 0;
            end
            for (int i = 0; i < N; i++)
                if (src_valid[i] && rdy[i])
                    q[i].push_back({src_rob_idx[i], src_rd_addr[i], src_data[i]});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // Per-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                logic [N-1:0] er;
                for (int i = 0; i < N; i++) er[i] = (q[i].size() != DEPTH);
                chk("src_ready", 64'(src_ready), 64'(er));
                chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
                if (exp_valid) begin
                    chk("cdb_src",  64'(cdb_src),     64'(exp_src));
                    chk("cdb_rob",  64'(cdb_rob_idx), 64'(exp_rob));
                    chk("cdb_rd",   64'(cdb_rd_addr), 64'(exp_rd));
                    chk("cdb_data", 64'(cdb_data),    64'(exp_data));
                end
                if (cdb_valid) begin
                    $display("bcast t=%0t src=%0d rob=%0d rd=%0d data=%08h",
                             $time, cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data);
                    if (bp_rec && cdb_src == 2'd2) bp_robs.push_back(cdb_rob_idx);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid = '0; flush = 1'b0;
        src_rob_idx = '0; src_rd_addr = '0; src_data = '0;
    endtask

    task automatic put(input int i, input logic [4:0] rob, input logic [4:0] rd, input logic [31:0] d);
        src_valid[i] = 1'b1; src_rob_idx[i] = rob; src_rd_addr[i] = rd; src_data[i] = d;
    endtask

    initial begin
        int n2;
        bit saw_full;
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_src",   64'(cdb_src), 64'd0);
        chk("rst_rob",   64'(cdb_rob_idx), 64'd0);
        chk("rst_data",  64'(cdb_data), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'hF);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Single source: visible in cycle 2 only
        cyc(); put(1, 5'd5, 5'd3, 32'hDEADBEEF);
        @(negedge clk); chk("single_c0_valid", 64'(cdb_valid), 64'd0);
        cyc(); idle();
        @(negedge clk); chk("single_c1_valid", 64'(cdb_valid), 64'd0);
        cyc();
        @(negedge clk);
        chk("single_c2_valid", 64'(cdb_valid), 64'd1);
        chk("single_c2_src",   64'(cdb_src), 64'd1);
        chk("single_c2_rob",   64'(cdb_rob_idx), 64'd5);
        chk("single_c2_rd",    64'(cdb_rd_addr), 64'd3);
        chk("single_c2_data",  64'(cdb_data), 64'hDEADBEEF);
        cyc();
        @(negedge clk); chk("single_c3_valid", 64'(cdb_valid), 64'd0);

        // Reset again so the priority pointer is back at 0
        #2 rst_n = 1'b0;
        cyc(); cyc();
        #2 rst_n = 1'b1;

        // All four contend: 0,1,2,3 in cycles 2..5
        cyc();
        for (int i = 0; i < N; i++) put(i, 5'(i), 5'(i + 1), $urandom);
        cyc(); idle();
        for (int i = 0; i < N; i++) begin
            cyc();
            @(negedge clk);
            chk("rr_valid", 64'(cdb_valid), 64'd1);
            chk("rr_src",   64'(cdb_src), 64'(i));
            chk("rr_rob",   64'(cdb_rob_idx), 64'(i));
        end
        cyc();
        @(negedge clk); chk("rr_end_valid", 64'(cdb_valid), 64'd0);

        // Rotation: src 3 alone, then 0 and 3 together -> 0 first
        cyc(); put(3, 5'd20, 5'd1, 32'h3333_0000);
        cyc(); idle();
        cyc(); cyc();
        put(0, 5'd21, 5'd2, 32'h0000_0001);
        put(3, 5'd22, 5'd4, 32'h3333_0001);
        cyc(); idle();
        cyc();
        @(negedge clk);
        chk("rot_first_src", 64'(cdb_src), 64'd0);
        chk("rot_first_rob", 64'(cdb_rob_idx), 64'd21);
        cyc();
        @(negedge clk);
        chk("rot_second_src", 64'(cdb_src), 64'd3);
        chk("rot_second_rob", 64'(cdb_rob_idx), 64'd22);
        repeat (3) cyc();

        // Backpressure: src 2 offers rob 10..14 while everyone else pushes
        n2 = 0; saw_full = 0; bp_rec = 1'b1;
        for (int c = 0; c < 80 && n2 < 5; c++) begin
            cyc();
            for (int i = 0; i < N; i++)
                if (i != 2) put(i, 5'($urandom_range(16, 31)), 5'($urandom), $urandom);
            put(2, 5'(10 + n2), 5'd9, 32'hB000_0000 + 32'(n2));
            @(negedge clk);
            if (src_ready[2]) n2++;
            else saw_full = 1;
        end
        chk("bp_all_accepted", 64'(n2), 64'd5);
        chk("bp_saw_not_ready", 64'(saw_full), 64'd1);
        cyc(); idle();
        repeat (20) cyc();
        bp_rec = 1'b0;
        chk("bp_count", 64'(bp_robs.size()), 64'd5);
        for (int i = 0; i < bp_robs.size() && i < 5; i++)
            chk("bp_order", 64'(bp_robs[i]), 64'(10 + i));

        // Flush with all FIFOs loaded and src 0 offering rob 7
        for (int c = 0; c < 5; c++) begin
            cyc();
            for (int i = 0; i < N; i++) put(i, 5'(16 + c), 5'(i), $urandom);
        end
        cyc(); idle(); flush = 1'b1; put(0, 5'd7, 5'd7, 32'h0000_0007);
        cyc(); idle();
        @(negedge clk);
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_ready", 64'(src_ready), 64'hF);
        for (int c = 0; c < 3; c++) begin
            cyc();
            @(negedge clk); chk("flush_quiet", 64'(cdb_valid), 64'd0);
        end

        // Asynchronous reset while broadcasting
        for (int c = 0; c < 3; c++) begin
            cyc();
            for (int i = 0; i < N; i++) put(i, 5'(c * 4 + i), 5'(i), $urandom);
        end
        cyc(); idle();
        @(negedge clk); chk("arst_pre_valid", 64'(cdb_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid_now", 64'(cdb_valid), 64'd0);
        chk("arst_ready_now", 64'(src_ready), 64'hF);
        chk("arst_rob_now",   64'(cdb_rob_idx), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            @(negedge clk); chk("arst_quiet", 64'(cdb_valid), 64'd0);
        end

        // Randomized traffic with occasional flush
        for (int c = 0; c < 500; c++) begin
            cyc();
            src_valid = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                src_rob_idx[i] = 5'($urandom);
                src_rd_addr[i] = 5'($urandom);
                src_data[i]    = $urandom;
            end
            flush = ($urandom_range(0, 31) == 0);
        end
        cyc(); idle();
        repeat (12) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
